// File: rtl/twiddle_mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : twiddle_mult_pkg
//  Description : Shared widths, types, twiddle table and round/saturate
//                helper for the 16-point pipelined FFT twiddle stage.
//  Revision    : 1.0  initial release
// ============================================================================
package twiddle_mult_pkg;

  localparam int DW = 10;           // data word length, Q(DW,DW-1)
  localparam int WL = 10;           // twiddle word length, Q(WL,WL-1)
  localparam int WN = 3;            // twiddle address width
  localparam int N  = 16;           // FFT length / frame length
  localparam int CW = $clog2(N);    // sample counter width
  localparam int PW = DW + WL;      // product width
  localparam int SW = DW + WL + 1;  // sum width (one guard bit)

  typedef logic signed [DW-1:0] data_t;
  typedef logic signed [WL-1:0] tw_t;
  typedef logic signed [PW-1:0] prod_t;
  typedef logic signed [SW-1:0] sum_t;

  typedef struct packed {
    tw_t re;
    tw_t im;
  } twiddle_t;

  // W16^k for k = 0..7, scaled by 2^(WL-1); +1.0 is clipped to 511/512.
  localparam twiddle_t c_TW_ROM [2**WN] = '{
    '{ 10'sd511,  10'sd0   },
    '{ 10'sd473, -10'sd196 },
    '{ 10'sd362, -10'sd362 },
    '{ 10'sd196, -10'sd473 },
    '{ 10'sd0,   -10'sd511 },
    '{-10'sd196, -10'sd473 },
    '{-10'sd362, -10'sd362 },
    '{-10'sd473, -10'sd196 }
  };

  localparam sum_t  c_RND      = sum_t'(2**(WL-2));
  localparam sum_t  c_SAT_MAX  = sum_t'(2**(DW-1) - 1);
  localparam sum_t  c_SAT_MIN  = sum_t'(-(2**(DW-1)));
  localparam data_t c_DATA_MAX = data_t'(2**(DW-1) - 1);
  localparam data_t c_DATA_MIN = data_t'(-(2**(DW-1)));

  // Round half up at bit WL-2, drop the WL-1 fraction bits, clip to DW bits.
  function automatic data_t roundSat(input sum_t x);
    sum_t w_rnd;
    sum_t w_shr;
    w_rnd = x + c_RND;
    w_shr = w_rnd >>> (WL - 1);
    if (w_shr > c_SAT_MAX) begin
      return c_DATA_MAX;
    end else if (w_shr < c_SAT_MIN) begin
      return c_DATA_MIN;
    end
    return w_shr[DW-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/twiddle_mult_if.sv
`default_nettype none
// ============================================================================
//  Module      : twiddle_mult_if
//  Description : Sample stream, TW_ROM lookup and product stream of the
//                twiddle-multiply stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface twiddle_mult_if;
  import twiddle_mult_pkg::*;

  logic          iVALID;
  logic          iSOF;
  data_t         iDATA_RE;
  data_t         iDATA_IM;
  logic [WN-1:0] twiddle_addr;
  tw_t           iTW_RE;
  tw_t           iTW_IM;
  logic          oVALID;
  logic          oSOF;
  data_t         oDATA_RE;
  data_t         oDATA_IM;

  // Upstream/driver side: supplies samples and twiddles, receives products.
  modport master (
    output iVALID, iSOF, iDATA_RE, iDATA_IM, iTW_RE, iTW_IM,
    input  twiddle_addr, oVALID, oSOF, oDATA_RE, oDATA_IM
  );

  // Twiddle stage side.
  modport slave (
    input  iVALID, iSOF, iDATA_RE, iDATA_IM, iTW_RE, iTW_IM,
    output twiddle_addr, oVALID, oSOF, oDATA_RE, oDATA_IM
  );

endinterface
`default_nettype wire

// File: rtl/twiddle_mult_cmult_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : cmult_pipe
//  Description : Complex multiply datapath: S2 partial products, S3 combine,
//                round, saturate or bypass.
//  Revision    : 1.0  initial release
// ============================================================================
module cmult_pipe
  import twiddle_mult_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_s1Valid,
  input  data_t i_s1Re,
  input  data_t i_s1Im,
  input  tw_t   i_twRe,
  input  tw_t   i_twIm,
  input  logic  i_s2Valid,
  input  logic  i_s2Byp,
  output data_t o_re,
  output data_t o_im
);

  prod_t w_aExt;
  prod_t w_bExt;
  prod_t w_cExt;
  prod_t w_dExt;
  prod_t r_ac;
  prod_t r_bd;
  prod_t r_ad;
  prod_t r_bc;
  data_t r_dlyRe;
  data_t r_dlyIm;
  sum_t  w_re;
  sum_t  w_im;
  data_t r_oRe;
  data_t r_oIm;

  // Sign-extend operands to full product width so the low PW bits are exact.
  always_comb begin
    w_aExt = {{WL{i_s1Re[DW-1]}}, i_s1Re};
    w_bExt = {{WL{i_s1Im[DW-1]}}, i_s1Im};
    w_cExt = {{DW{i_twRe[WL-1]}}, i_twRe};
    w_dExt = {{DW{i_twIm[WL-1]}}, i_twIm};
  end

  // S2: partial products, plus the raw sample kept for bypass.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ac    <= '0;
      r_bd    <= '0;
      r_ad    <= '0;
      r_bc    <= '0;
      r_dlyRe <= '0;
      r_dlyIm <= '0;
    end else if (i_s1Valid) begin
      r_ac    <= w_aExt * w_cExt;
      r_bd    <= w_bExt * w_dExt;
      r_ad    <= w_aExt * w_dExt;
      r_bc    <= w_bExt * w_cExt;
      r_dlyRe <= i_s1Re;
      r_dlyIm <= i_s1Im;
    end
  end

  // One guard bit so ac-bd and ad+bc cannot wrap before saturation.
  always_comb begin
    w_re = {r_ac[PW-1], r_ac} - {r_bd[PW-1], r_bd};
    w_im = {r_ad[PW-1], r_ad} + {r_bc[PW-1], r_bc};
  end

  // S3: registered result; holds while no valid sample arrives.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_oRe <= '0;
      r_oIm <= '0;
    end else if (i_s2Valid) begin
      r_oRe <= i_s2Byp ? r_dlyRe : roundSat(w_re);
      r_oIm <= i_s2Byp ? r_dlyIm : roundSat(w_im);
    end
  end

  assign o_re = r_oRe;
  assign o_im = r_oIm;

endmodule
`default_nettype wire

// File: rtl/twiddle_mult.sv
`default_nettype none
// ============================================================================
//  Module      : twiddle_mult
//  Description : First-stage DIF twiddle multiply of the 16-point FFT.
//                Counts samples per frame, addresses TW_ROM, aligns
//                valid/SOF/bypass with the 3-stage complex multiplier.
//  Revision    : 1.0  initial release
// ============================================================================
module twiddle_mult
  import twiddle_mult_pkg::*;
(
  input  logic          iCLK,
  input  logic          iRST,
  twiddle_mult_if.slave bus
);

  logic [CW-1:0] w_cnt;
  logic [CW-1:0] r_cnt;
  logic          r_s1Valid;
  logic          r_s1Sof;
  logic          r_s1Byp;
  data_t         r_s1Re;
  data_t         r_s1Im;
  logic [WN-1:0] r_twAddr;
  logic          r_s2Valid;
  logic          r_s2Sof;
  logic          r_s2Byp;
  logic          r_oValid;
  logic          r_oSof;
  data_t         w_oRe;
  data_t         w_oIm;

  // Index of the current sample; a start-of-frame forces realignment to 0.
  always_comb begin
    w_cnt = (bus.iVALID && bus.iSOF) ? '0 : r_cnt;
  end

  // Sample counter advances only on valid samples, so gaps are tolerated.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_cnt <= '0;
    end else if (bus.iVALID) begin
      r_cnt <= w_cnt + CW'(1);
    end
  end

  // S1: capture sample, flags and the twiddle address for the ROM lookup.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_s1Valid <= 1'b0;
      r_s1Sof   <= 1'b0;
      r_s1Byp   <= 1'b0;
      r_s1Re    <= '0;
      r_s1Im    <= '0;
      r_twAddr  <= '0;
    end else begin
      r_s1Valid <= bus.iVALID;
      r_s1Sof   <= bus.iVALID && (w_cnt == '0);
      if (bus.iVALID) begin
        r_s1Byp  <= ~w_cnt[CW-1];
        r_s1Re   <= bus.iDATA_RE;
        r_s1Im   <= bus.iDATA_IM;
        r_twAddr <= w_cnt[CW-1] ? w_cnt[WN-1:0] : '0;
      end
    end
  end

  // S2/S3 control alignment alongside the multiplier datapath.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_s2Valid <= 1'b0;
      r_s2Sof   <= 1'b0;
      r_s2Byp   <= 1'b0;
      r_oValid  <= 1'b0;
      r_oSof    <= 1'b0;
    end else begin
      r_s2Valid <= r_s1Valid;
      r_s2Sof   <= r_s1Sof;
      if (r_s1Valid) begin
        r_s2Byp <= r_s1Byp;
      end
      r_oValid  <= r_s2Valid;
      r_oSof    <= r_s2Sof;
    end
  end

  cmult_pipe u_cmult (
    .i_clk     (iCLK),
    .i_rst     (iRST),
    .i_s1Valid (r_s1Valid),
    .i_s1Re    (r_s1Re),
    .i_s1Im    (r_s1Im),
    .i_twRe    (bus.iTW_RE),
    .i_twIm    (bus.iTW_IM),
    .i_s2Valid (r_s2Valid),
    .i_s2Byp   (r_s2Byp),
    .o_re      (w_oRe),
    .o_im      (w_oIm)
  );

  assign bus.twiddle_addr = r_twAddr;
  assign bus.oVALID       = r_oValid;
  assign bus.oSOF         = r_oSof;
  assign bus.oDATA_RE     = w_oRe;
  assign bus.oDATA_IM     = w_oIm;

endmodule
`default_nettype wire

// File: tb/tb_twiddle_mult.sv
`default_nettype none
// ============================================================================
//  Module      : tb_twiddle_mult
//  Description : Self-checking bench for twiddle_mult with a behavioural
//                TW_ROM and an output scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_twiddle_mult;

  typedef struct {
    int n;
    int re;
    int im;
    int expRe;
    int expIm;
  } vec_t;

  typedef struct {
    int re;
    int im;
    int sof;
    int cyc;
  } exp_t;

  localparam logic signed [9:0] ROM_RE [8] = '{511, 473, 362, 196, 0, -196, -362, -473};
  localparam logic signed [9:0] ROM_IM [8] = '{0, -196, -362, -473, -511, -473, -362, -196};

  logic iCLK = 1'b0;
  logic iRST;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t monE;
  vec_t vecs[9];

  twiddle_mult_if bus();

  twiddle_mult dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  // Behavioural TW_ROM: combinational from the registered address.
  assign bus.iTW_RE = ROM_RE[bus.twiddle_addr];
  assign bus.iTW_IM = ROM_IM[bus.twiddle_addr];

  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference arithmetic: bypass for n<8, else multiply by W16^(n-8), round half up, clip.
  function automatic void model(input int n, input int a, input int b, output int re, output int im);
    int c, d, pr, pi;
    if (n < 8) begin
      re = a;
      im = b;
    end else begin
      c  = int'(ROM_RE[n-8]);
      d  = int'(ROM_IM[n-8]);
      pr = (a * c - b * d + 256) >>> 9;
      pi = (a * d + b * c + 256) >>> 9;
      re = (pr > 511) ? 511 : (pr < -512) ? -512 : pr;
      im = (pi > 511) ? 511 : (pi < -512) ? -512 : pi;
    end
  endfunction

  // Drive one valid sample, record its expected output and check the ROM address.
  task automatic sampleExp(input int n, input bit sof, input int a, input int b,
                           input int er, input int ei);
    bus.iVALID   = 1'b1;
    bus.iSOF     = sof;
    bus.iDATA_RE = 10'(a);
    bus.iDATA_IM = 10'(b);
    @(posedge iCLK);
    #1;
    q.push_back('{er, ei, (n == 0) ? 1 : 0, cyc + 2});
    check("twiddle_addr", int'(bus.twiddle_addr), (n >= 8) ? n - 8 : 0);
  endtask

  task automatic sample(input int n, input bit sof, input int a, input int b);
    int er, ei;
    model(n, a, b, er, ei);
    sampleExp(n, sof, a, b, er, ei);
  endtask

  task automatic idle(input int cycles);
    bus.iVALID = 1'b0;
    bus.iSOF   = 1'b0;
    repeat (cycles) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  task automatic randSample(input int n, input bit sof);
    sample(n, sof, int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512);
  endtask

  // Scoreboard: every valid output must match the oldest outstanding expectation.
  always @(negedge iCLK) begin
    if (bus.oVALID === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual re=%0d im=%0d required no output (cycle %0d)",
                 $signed(bus.oDATA_RE), $signed(bus.oDATA_IM), cyc);
      end else begin
        monE = q.pop_front();
        check("out_re", int'($signed(bus.oDATA_RE)), monE.re);
        check("out_im", int'($signed(bus.oDATA_IM)), monE.im);
        check("out_sof", int'(bus.oSOF), monE.sof);
        check("latency", cyc, monE.cyc);
      end
    end else if (bus.oSOF === 1'b1) begin
      check("sof_without_valid", 1, 0);
    end
  end

  initial begin
    vecs[0] = '{0,   511, -512, 511, -512};
    vecs[1] = '{8,   200, -100, 200, -100};
    vecs[2] = '{9,   100,    0,  92,  -38};
    vecs[3] = '{10,  256,    0, 181, -181};
    vecs[4] = '{12,  100,   50,  50, -100};
    vecs[5] = '{13, -512,    0, 196,  473};
    vecs[6] = '{14, -512, -512,   0,  511};
    vecs[7] = '{14,  511,  511,   0, -512};
    vecs[8] = '{15,    0,  100,  38,  -92};

    bus.iVALID   = 1'b0;
    bus.iSOF     = 1'b0;
    bus.iDATA_RE = '0;
    bus.iDATA_IM = '0;
    iRST = 1'b1;
    repeat (2) @(posedge iCLK);
    #1;
    check("reset_ovalid", int'(bus.oVALID), 0);
    check("reset_osof", int'(bus.oSOF), 0);
    check("reset_re", int'($signed(bus.oDATA_RE)), 0);
    check("reset_im", int'($signed(bus.oDATA_IM)), 0);
    check("reset_addr", int'(bus.twiddle_addr), 0);
    iRST = 1'b0;
    idle(2);

    // Bypass half-frame: values come out unchanged.
    for (int n = 0; n < 8; n++) sampleExp(n, n == 0, 100 + n, -n, 100 + n, -n);
    idle(4);

    // Table vectors: each placed at its slot inside an otherwise zero frame.
    for (int v = 0; v < 9; v++) begin
      for (int n = 0; n < 16; n++) begin
        if (n == vecs[v].n) sampleExp(n, n == 0, vecs[v].re, vecs[v].im, vecs[v].expRe, vecs[v].expIm);
        else sampleExp(n, n == 0, 0, 0, 0, 0);
      end
    end
    idle(4);

    // Gap between n=7 and n=8, then a frame that relies on the counter wrapping.
    for (int n = 0; n < 8; n++) randSample(n, n == 0);
    idle(3);
    for (int n = 8; n < 16; n++) randSample(n, 1'b0);
    for (int n = 0; n < 16; n++) randSample(n, 1'b0);
    idle(1);
    for (int n = 0; n < 16; n++) begin
      randSample(n, n == 0);
      if (n == 11) idle(2);
    end

    // Mid-frame SOF realigns the count immediately.
    for (int n = 0; n < 5; n++) randSample(n, n == 0);
    for (int n = 0; n < 16; n++) randSample(n, n == 0);
    idle(5);

    // Reset mid-frame: only samples already through the pipe may appear.
    for (int n = 0; n < 5; n++) begin
      bus.iVALID   = 1'b1;
      bus.iSOF     = (n == 0);
      bus.iDATA_RE = 10'(20 + n);
      bus.iDATA_IM = 10'(-20 - n);
      @(posedge iCLK);
      #1;
      if (n < 3) q.push_back('{20 + n, -20 - n, (n == 0) ? 1 : 0, cyc + 2});
    end
    bus.iVALID = 1'b0;
    bus.iSOF   = 1'b0;
    iRST = 1'b1;
    @(posedge iCLK);
    #1;
    iRST = 1'b0;
    check("rst_ovalid", int'(bus.oVALID), 0);
    check("rst_osof", int'(bus.oSOF), 0);
    check("rst_re", int'($signed(bus.oDATA_RE)), 0);
    check("rst_im", int'($signed(bus.oDATA_IM)), 0);
    check("rst_addr", int'(bus.twiddle_addr), 0);
    check("rst_pending", q.size(), 0);
    q.delete();
    idle(5);
    for (int n = 0; n < 16; n++) randSample(n, n == 0);

    // Drain with a bounded wait.
    begin
      int guard;
      guard = 0;
      bus.iVALID = 1'b0;
      bus.iSOF   = 1'b0;
      while (q.size() != 0 && guard < 20) begin
        @(posedge iCLK);
        guard++;
      end
      if (q.size() != 0) check("drain_timeout", q.size(), 0);
      idle(2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
